alu_uart_frame_engine: RTL and testbench

//  Parametrised byte-stream command engine between a UART RX/TX FIFO pair and an NB_DATA-wide combinational ALU.
//  - Receives an opcode byte, then operand A and operand B as NB_DATA/8 bytes each, LSB first.
//  - Drives the ALU, captures its result and returns it as NB_DATA/8 bytes, LSB first.
//  - Adds an inter-byte receive timeout and an optional frame checksum.

---
 rtl/alu_uart_frame_engine_if.sv | 32 +++
 rtl/alu_uart_frame_engine.sv | 155 +++++++++++++++
 tb/tb_alu_uart_frame_engine.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_uart_frame_engine_if.sv
// Purpose: bundles the RX/TX FIFO handshake and ALU operand/result buses of the frame engine.
// Latency: none, wiring only.
// Backpressure: carries i_fifo_rx_empty / i_fifo_tx_full toward the engine; signal names are engine-relative.
interface alu_uart_frame_engine_if #(
   parameter int NB_DATA   = 16,
   parameter int NB_OPCODE = 6
);
   logic [7:0]           i_data_to_read;
   logic                 i_fifo_rx_empty;
   logic                 i_fifo_tx_full;
   logic [NB_DATA-1:0]   i_alu_result;
   logic                 o_fifo_rx_read;
   logic                 o_fifo_tx_write;
   logic [7:0]           o_data_to_write;
   logic [NB_OPCODE-1:0] o_alu_opcode;
   logic [NB_DATA-1:0]   o_alu_op_A;
   logic [NB_DATA-1:0]   o_alu_op_B;

   // Engine side.
   modport master (
      input  i_data_to_read, i_fifo_rx_empty, i_fifo_tx_full, i_alu_result,
      output o_fifo_rx_read, o_fifo_tx_write, o_data_to_write,
      output o_alu_opcode, o_alu_op_A, o_alu_op_B
   );

   // FIFO/ALU environment side.
   modport slave (
      output i_data_to_read, i_fifo_rx_empty, i_fifo_tx_full, i_alu_result,
      input  o_fifo_rx_read, o_fifo_tx_write, o_data_to_write,
      input  o_alu_opcode, o_alu_op_A, o_alu_op_B
   );
endinterface

// File: rtl/alu_uart_frame_engine.sv
// Purpose: byte-stream command engine (opcode, A, B LSB-first in; result LSB-first out) around an external ALU.
// Latency: last operand/checksum byte consumed at edge N -> one S_EXEC cycle -> first TX write earliest in cycle N+2.
// Backpressure: pops RX only when non-empty (1 byte/cycle), holds in S_TX while TX full; ALU_UART_FRAME_CKSUM_EN adds checksum byte.
module alu_uart_frame_engine #(
   parameter int NB_DATA     = 16,
   parameter int NB_OPCODE   = 6,
   parameter int TIMEOUT_CYC = 1000,
   parameter int NB_TOCNT    = 16
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   alu_uart_frame_engine_if.master  if_bus,
   output logic                     o_busy,
   output logic                     o_err_timeout,
   output logic                     o_err_cksum
);
   localparam int NBYTES = NB_DATA / 8;
   localparam int NB_IDX = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [NB_IDX-1:0]   IDX_LAST = NB_IDX'(NBYTES - 1);
   localparam logic [NB_TOCNT-1:0] TO_LAST  = NB_TOCNT'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {S_OP, S_A, S_B, S_CK, S_EXEC, S_TX} state_t;

   state_t               r_state, w_state_nxt;
   logic [NB_IDX-1:0]    r_idx, w_idx_inc;
   logic [NB_TOCNT-1:0]  r_tocnt;
   logic [NB_OPCODE-1:0] r_opcode;
   logic [NB_DATA-1:0]   r_op_a, r_op_b, r_result;
   logic                 r_err_timeout, r_err_cksum;
   logic                 w_rx_read, w_tx_write, w_to_active, w_timeout, w_ck_bad, w_ck_ok;
   logic [7:0]           w_tx_byte;
`ifdef ALU_UART_FRAME_CKSUM_EN
   logic [7:0]           r_ck;
`endif

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= S_OP;
      else         r_state <= w_state_nxt;
   end

   // Handshakes, timeout detection and next-state selection.
   always_comb begin
      w_state_nxt = r_state;
      w_rx_read   = 1'b0;
      w_tx_write  = 1'b0;
      w_tx_byte   = 8'h00;
      w_idx_inc   = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      w_to_active = (TIMEOUT_CYC != 0) && (r_state inside {S_A, S_B, S_CK});
      w_timeout   = w_to_active && if_bus.i_fifo_rx_empty && (r_tocnt == TO_LAST);
`ifdef ALU_UART_FRAME_CKSUM_EN
      w_ck_ok     = (if_bus.i_data_to_read == r_ck);
`else
      w_ck_ok     = 1'b1;
`endif
      if (!i_reset && (r_state inside {S_OP, S_A, S_B, S_CK}))
         w_rx_read = !if_bus.i_fifo_rx_empty;
      if (r_state == S_TX) begin
         w_tx_write = !i_reset && !if_bus.i_fifo_tx_full;
         w_tx_byte  = r_result[r_idx*8 +: 8];
      end
      w_ck_bad = (r_state == S_CK) && w_rx_read && !w_ck_ok;
      case (r_state)
         S_OP: if (w_rx_read) w_state_nxt = S_A;
         S_A: begin
            if (w_rx_read) begin
               if (r_idx == IDX_LAST) w_state_nxt = S_B;
            end else if (w_timeout) w_state_nxt = S_OP;
         end
         S_B: begin
            if (w_rx_read) begin
`ifdef ALU_UART_FRAME_CKSUM_EN
               if (r_idx == IDX_LAST) w_state_nxt = S_CK;
`else
               if (r_idx == IDX_LAST) w_state_nxt = S_EXEC;
`endif
            end else if (w_timeout) w_state_nxt = S_OP;
         end
         S_CK: begin
            // A bad checksum skips the ALU and returns the 0xEE error pattern.
            if (w_rx_read)      w_state_nxt = w_ck_ok ? S_EXEC : S_TX;
            else if (w_timeout) w_state_nxt = S_OP;
         end
         S_EXEC: w_state_nxt = S_TX;
         S_TX: if (w_tx_write && (r_idx == IDX_LAST)) w_state_nxt = S_OP;
         default: w_state_nxt = S_OP;
      endcase
   end

   // Datapath: byte assembly, timeout counter, result capture and error pulses.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_idx         <= '0;
         r_tocnt       <= '0;
         r_opcode      <= '0;
         r_op_a        <= '0;
         r_op_b        <= '0;
         r_result      <= '0;
         r_err_timeout <= 1'b0;
         r_err_cksum   <= 1'b0;
`ifdef ALU_UART_FRAME_CKSUM_EN
         r_ck          <= '0;
`endif
      end else begin
         r_err_timeout <= w_timeout;
         r_err_cksum   <= w_ck_bad;
         // A consumed byte wins over an expiring timeout: the counter just clears.
         if (w_to_active && !w_rx_read && !w_timeout) r_tocnt <= r_tocnt + 1'b1;
         else                                         r_tocnt <= '0;
         case (r_state)
            S_OP: if (w_rx_read) begin
               r_opcode <= if_bus.i_data_to_read[NB_OPCODE-1:0];
               r_idx    <= '0;
`ifdef ALU_UART_FRAME_CKSUM_EN
               r_ck     <= if_bus.i_data_to_read;
`endif
            end
            S_A: if (w_rx_read) begin
               r_op_a[r_idx*8 +: 8] <= if_bus.i_data_to_read;
               r_idx                <= w_idx_inc;
`ifdef ALU_UART_FRAME_CKSUM_EN
               r_ck                 <= r_ck ^ if_bus.i_data_to_read;
`endif
            end
            S_B: if (w_rx_read) begin
               r_op_b[r_idx*8 +: 8] <= if_bus.i_data_to_read;
               r_idx                <= w_idx_inc;
`ifdef ALU_UART_FRAME_CKSUM_EN
               r_ck                 <= r_ck ^ if_bus.i_data_to_read;
`endif
            end
            S_CK: if (w_ck_bad) begin
               r_result <= {NBYTES{8'hEE}};
               r_idx    <= '0;
            end
            S_EXEC: begin
               r_result <= if_bus.i_alu_result;
               r_idx    <= '0;
            end
            S_TX: if (w_tx_write) r_idx <= w_idx_inc;
            default: ;
         endcase
      end
   end

   assign if_bus.o_fifo_rx_read  = w_rx_read;
   assign if_bus.o_fifo_tx_write = w_tx_write;
   assign if_bus.o_data_to_write = w_tx_byte;
   assign if_bus.o_alu_opcode    = r_opcode;
   assign if_bus.o_alu_op_A      = r_op_a;
   assign if_bus.o_alu_op_B      = r_op_b;
   assign o_busy                 = (r_state != S_OP);
   assign o_err_timeout          = r_err_timeout;
   assign o_err_cksum            = r_err_cksum;
endmodule

// File: tb/tb_alu_uart_frame_engine.sv
// Purpose: directed scoreboard bench for alu_uart_frame_engine (NB_DATA=16, TIMEOUT_CYC=8, ALU op 6'h20 = A+B).
// Latency: expected TX bytes are queued when a frame is driven and popped as the engine writes them.
// Backpressure: drives RX empty gaps and TX full holds; honours ALU_UART_FRAME_CKSUM_EN for the checksum byte.
module tb_alu_uart_frame_engine;
   localparam int NB_DATA = 16;
`ifdef ALU_UART_FRAME_CKSUM_EN
   localparam int NFR = 6;
`else
   localparam int NFR = 5;
`endif

   logic clk = 1'b0;
   logic rst;
   logic busy, err_to, err_ck;
   int   n_tests = 0, n_fail = 0;
   int   cyc = 0, rd_cnt = 0, tx_cnt = 0, to_cnt = 0, ck_cnt = 0;
   int   c0, r0, t0, x0, k0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   alu_uart_frame_engine_if #(.NB_DATA(NB_DATA), .NB_OPCODE(6)) bus ();

   alu_uart_frame_engine #(.NB_DATA(NB_DATA), .NB_OPCODE(6), .TIMEOUT_CYC(8), .NB_TOCNT(16)) dut (
      .i_clk(clk), .i_reset(rst), .if_bus(bus.master),
      .o_busy(busy), .o_err_timeout(err_to), .o_err_cksum(err_ck)
   );

   // Bench ALU: 6'h20 adds, everything else XORs.
   always_comb
      bus.i_alu_result = (bus.o_alu_opcode == 6'h20) ? bus.o_alu_op_A + bus.o_alu_op_B
                                                    : bus.o_alu_op_A ^ bus.o_alu_op_B;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Monitor, sampled mid-cycle: event counters and scoreboard pop on each TX write.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.o_fifo_rx_read) rd_cnt++;
         if (err_to) to_cnt++;
         if (err_ck) ck_cnt++;
         if (bus.o_fifo_tx_write) begin
            tx_cnt++;
            if (exp_q.size() == 0) chk("tx_unexpected_byte", 32'(bus.o_data_to_write), 32'hFFFF_FFFF);
            else                   chk("tx_byte", 32'(bus.o_data_to_write), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic send(input logic [7:0] b);
      bit took = 1'b0;
      int n    = 0;
      bus.i_data_to_read  = b;
      bus.i_fifo_rx_empty = 1'b0;
      while (!took && n < 50) begin
         @(negedge clk);
         took = bus.o_fifo_rx_read;
         step();
         n++;
      end
      bus.i_fifo_rx_empty = 1'b1;
      bus.i_data_to_read  = 8'h00;
      chk("rx_accept", 32'(took), 32'd1);
   endtask

   task automatic send_frame(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                             input int gap, input bit bad_ck);
      logic [15:0] r;
      logic [7:0]  ck;
      r  = (op[5:0] == 6'h20) ? a + b : a ^ b;
      ck = op ^ a[7:0] ^ a[15:8] ^ b[7:0] ^ b[15:8];
      if (bad_ck) begin
         exp_q.push_back(8'hEE); exp_q.push_back(8'hEE);
      end else begin
         exp_q.push_back(r[7:0]); exp_q.push_back(r[15:8]);
      end
      send(op);      idle(gap);
      send(a[7:0]);  idle(gap);
      send(a[15:8]); idle(gap);
      send(b[7:0]);  idle(gap);
      send(b[15:8]);
`ifdef ALU_UART_FRAME_CKSUM_EN
      idle(gap);
      send(bad_ck ? ck ^ 8'h5A : ck);
`endif
   endtask

   task automatic wait_tx(input string tag);
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         step();
         n++;
      end
      chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
      chk({tag, "_busy_low"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      bus.i_data_to_read  = 8'h00;
      bus.i_fifo_rx_empty = 1'b1;
      bus.i_fifo_tx_full  = 1'b0;
      idle(3);
      rst = 1'b0;
      chk("rst_rx_read",  32'(bus.o_fifo_rx_read), 32'd0);
      chk("rst_tx_write", 32'(bus.o_fifo_tx_write), 32'd0);
      chk("rst_tx_data",  32'(bus.o_data_to_write), 32'd0);
      chk("rst_opcode",   32'(bus.o_alu_opcode), 32'd0);
      chk("rst_op_a",     32'(bus.o_alu_op_A), 32'd0);
      chk("rst_op_b",     32'(bus.o_alu_op_B), 32'd0);
      chk("rst_busy",     32'(busy), 32'd0);
      chk("rst_err_to",   32'(err_to), 32'd0);
      chk("rst_err_ck",   32'(err_ck), 32'd0);

      // Back-to-back frame: one pop per cycle, EXEC bubble, then first write.
      c0 = cyc; r0 = rd_cnt;
      send_frame(8'h20, 16'h1234, 16'h0101, 0, 1'b0);
      chk("b2b_cycles", 32'(cyc - c0), 32'(NFR));
      chk("b2b_reads",  32'(rd_cnt - r0), 32'(NFR));
      chk("exec_no_write", 32'(bus.o_fifo_tx_write), 32'd0);
      chk("exec_busy", 32'(busy), 32'd1);
      step();
      chk("tx_first_latency", 32'(bus.o_fifo_tx_write), 32'd1);
      wait_tx("b2b");

      // Gapped frame below the timeout threshold.
      t0 = to_cnt;
      send_frame(8'h20, 16'h1234, 16'h0101, 3, 1'b0);
      wait_tx("gap");
      chk("gap_no_timeout", 32'(to_cnt - t0), 32'd0);

      // Starved partial frame: one timeout, no TX, partial operand kept.
      t0 = to_cnt; x0 = tx_cnt;
      send(8'h20); send(8'h56);
      idle(10);
      chk("to_pulses", 32'(to_cnt - t0), 32'd1);
      chk("to_idle", 32'(busy), 32'd0);
      chk("to_no_tx", 32'(tx_cnt - x0), 32'd0);
      chk("to_partial_a", 32'(bus.o_alu_op_A), 32'h1256);
      send_frame(8'h20, 16'h0201, 16'h0403, 0, 1'b0);
      wait_tx("after_to");

      // TX full hold: nothing written, nothing lost, no timeout while waiting.
      bus.i_fifo_tx_full = 1'b1;
      x0 = tx_cnt; t0 = to_cnt;
      send_frame(8'h20, 16'h1234, 16'h0101, 0, 1'b0);
      idle(10);
      chk("full_no_write", 32'(tx_cnt - x0), 32'd0);
      chk("full_busy", 32'(busy), 32'd1);
      bus.i_fifo_tx_full = 1'b0;
      wait_tx("full");
      chk("full_writes", 32'(tx_cnt - x0), 32'd2);
      chk("full_no_timeout", 32'(to_cnt - t0), 32'd0);

      // Reset mid-frame discards the partial frame.
      send(8'h20); send(8'h34); send(8'h12);
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_op_a", 32'(bus.o_alu_op_A), 32'd0);
      chk("midrst_opcode", 32'(bus.o_alu_opcode), 32'd0);
      send_frame(8'h20, 16'h0510, 16'h0005, 0, 1'b0);
      wait_tx("midrst");

`ifdef ALU_UART_FRAME_CKSUM_EN
      k0 = ck_cnt;
      send_frame(8'h20, 16'h1234, 16'h0101, 0, 1'b0);
      wait_tx("ck_good");
      chk("ck_good_no_err", 32'(ck_cnt - k0), 32'd0);
      send_frame(8'h20, 16'h1234, 16'h0101, 0, 1'b1);
      wait_tx("ck_bad");
      chk("ck_bad_pulse", 32'(ck_cnt - k0), 32'd1);
`else
      k0 = 0;
      chk("ck_never", 32'(ck_cnt - k0), 32'd0);
`endif

      idle(3);
      chk("end_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
